// File: rtl/multiplicador_pkg.sv
// Shared definitions for the 4x4 shift-add multiplier: operand width,
// iteration count and control state encoding.
package multiplicador_pkg;

    localparam int unsigned LARGURA   = 4;
    localparam int unsigned ITERACOES = 4;

    typedef enum logic [1:0] {
        OCIOSO,
        SOMA_DESLOCA,
        FIM
    } estado_t;

endpackage

// File: rtl/acumulador_shift_add_if.sv
// Signal bundle between the shift-add accumulator stage, its requester and
// the external combinational Adder.
interface acumulador_shift_add_if;
    import multiplicador_pkg::*;

    logic                     Iniciar;
    logic [LARGURA-1:0]       Multiplicando;
    logic [LARGURA-1:0]       Multiplicador;
    logic [LARGURA:0]         Soma;
    logic [LARGURA-1:0]       OperandoA;
    logic [LARGURA-1:0]       OperandoB;
    logic [2*LARGURA-1:0]     Produto;
    logic                     Pronto;
    logic                     Ocupado;

    modport slave (
        input  Iniciar, Multiplicando, Multiplicador, Soma,
        output OperandoA, OperandoB, Produto, Pronto, Ocupado
    );

    modport master (
        output Iniciar, Multiplicando, Multiplicador, Soma,
        input  OperandoA, OperandoB, Produto, Pronto, Ocupado
    );

endinterface

// File: rtl/acumulador_shift_add.sv
// Control and datapath of the shift-add multiplier: four add/shift iterations
// around an external Adder, registered product and one-cycle done pulse.
module acumulador_shift_add #(
    parameter int unsigned LARGURA = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    acumulador_shift_add_if.slave bus
);
    import multiplicador_pkg::*;

    localparam int unsigned W      = LARGURA;
    localparam int unsigned CNT_W  = $clog2(ITERACOES);
    localparam logic [CNT_W-1:0] ULTIMA = CNT_W'(ITERACOES - 1);

    // The Adder and the interface are fixed at the package width.
    if (LARGURA != multiplicador_pkg::LARGURA) begin : g_largura_check
        $error("acumulador_shift_add: only LARGURA=4 is supported");
    end

    estado_t          estado_q, estado_d;
    logic [W-1:0]     m_q, m_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   produto_q, produto_d;
    logic             pronto_q, pronto_d;
    logic             ocupado_q, ocupado_d;

    // Next-state, datapath and status decode.
    always_comb begin
        estado_d  = estado_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        produto_d = produto_q;

        unique case (estado_q)
            OCIOSO: begin
                if (bus.Iniciar) begin
                    m_d      = bus.Multiplicando;
                    q_d      = bus.Multiplicador;
                    a_d      = '0;
                    cnt_d    = '0;
                    estado_d = SOMA_DESLOCA;
                end
            end
            SOMA_DESLOCA: begin
                // Adder carry lands in the new A MSB, so nothing is lost.
                if (q_q[0]) begin
                    {a_d, q_d} = {bus.Soma, q_q[W-1:1]};
                end else begin
                    {a_d, q_d} = {1'b0, a_q, q_q[W-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == ULTIMA) begin
                    produto_d = {a_d, q_d};
                    estado_d  = FIM;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        pronto_d  = (estado_d == FIM);
        ocupado_d = (estado_d == SOMA_DESLOCA);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado_q  <= OCIOSO;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            produto_q <= '0;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            produto_q <= produto_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign bus.OperandoA = a_q;
    assign bus.OperandoB = m_q;
    assign bus.Produto   = produto_q;
    assign bus.Pronto    = pronto_q;
    assign bus.Ocupado   = ocupado_q;

endmodule
